// File: rtl/anim_seq_if.sv
// anim_seq_if: control, timer-handshake and display signals of the LED frame sequencer
interface anim_seq_if #(parameter int F = 4);
  logic start;
  logic stop;
  logic [1:0] mode;
  logic [F-1:0] last;
  logic tick;
  logic trig;
  logic [F-1:0] frame;
  logic [2**F-1:0] led;
  logic busy;
  logic done;
  modport master (output start, stop, mode, last, tick, input trig, frame, led, busy, done);
  modport slave (input start, stop, mode, last, tick, output trig, frame, led, busy, done);
endinterface

// File: rtl/anim_seq.sv
// anim_seq: frame sequencer that arms the interval timer and steps a frame index per playback mode
module anim_seq #(parameter int F = 4) (
  input logic clk,
  input logic rst,
  anim_seq_if.slave bus
);
  localparam int N = 2**F;
  localparam logic [F-1:0] one = F'(1);
  typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;
  state_t state, state_n;
  logic [F-1:0] frame_r, frame_n, last_r, last_n;
  logic [1:0] mode_r, mode_n;
  logic dir, dir_n, done_r, done_n;
  logic at_end, at_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frame_r <= '0;
      last_r <= '0;
      mode_r <= '0;
      dir <= 1'b1;
      done_r <= 1'b0;
    end else begin
      state <= state_n;
      frame_r <= frame_n;
      last_r <= last_n;
      mode_r <= mode_n;
      dir <= dir_n;
      done_r <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    frame_n = frame_r;
    last_n = last_r;
    mode_n = mode_r;
    dir_n = dir;
    done_n = 1'b0;
    at_end = frame_r == last_r;
    at_zero = frame_r == '0;
    case (state)
      IDLE: if (bus.start) begin
        mode_n = bus.mode;
        last_n = bus.last;
        frame_n = bus.mode == 2'b11 ? bus.last : '0;
        dir_n = bus.mode != 2'b11;
        state_n = ARM;
      end
      ARM: state_n = bus.stop ? IDLE : WAIT;
      WAIT: if (bus.stop) begin
        state_n = IDLE;
      end else if (bus.tick) begin
        state_n = ARM;
        case (mode_r)
          2'b00: begin
            frame_n = at_end ? frame_r : frame_r + one;
            done_n = at_end;
            state_n = at_end ? IDLE : ARM;
          end
          2'b01: frame_n = at_end ? '0 : frame_r + one;
          2'b10: begin
            frame_n = dir ? (at_end ? (last_r == '0 ? '0 : last_r - one) : frame_r + one)
                          : (at_zero ? one : frame_r - one);
            dir_n = dir ? !(at_end && last_r != '0) : at_zero;
          end
          default: begin
            frame_n = at_zero ? frame_r : frame_r - one;
            done_n = at_zero;
            state_n = at_zero ? IDLE : ARM;
          end
        endcase
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.trig = state == ARM;
  assign bus.busy = state != IDLE;
  assign bus.frame = frame_r;
  assign bus.done = done_r;
  assign bus.led = state != IDLE ? N'(1) << frame_r : '0;
endmodule
